// File: rtl/stream_header_append_if.sv
// stream_header_append_if
// Stream word bundle of the header appender: the imager-side input word
// (dvi/dtypei/datai) and the DRAM-writer-side output word (dvo/dtypeo/datao).
// The master modport is the side that produces input words and consumes
// output words; the block itself connects to the slave modport.
// Also provides the stream word-type codes shared by design and bench.

`ifndef STREAM_DTYPE_DEFS
`define STREAM_DTYPE_DEFS
`define DTYPE_WIDTH        4
`define DTYPE_FRAME_START  4'h1
`define DTYPE_FRAME_END    4'h2
`define DTYPE_HEADER_START 4'h3
`define DTYPE_HEADER_END   4'h4
`define DTYPE_HEADER       4'h5
`define DTYPE_PIXEL_MASK   4'h8
`endif

interface stream_header_append_if #(
  parameter int DATA_WIDTH = 16
);
  logic                    dvi;
  logic [`DTYPE_WIDTH-1:0] dtypei;
  logic [DATA_WIDTH-1:0]   datai;
  logic                    dvo;
  logic [`DTYPE_WIDTH-1:0] dtypeo;
  logic [DATA_WIDTH-1:0]   datao;

  modport master (
    output dvi, dtypei, datai,
    input  dvo, dtypeo, datao
  );

  modport slave (
    input  dvi, dtypei, datai,
    output dvo, dtypeo, datao
  );
endinterface

// File: rtl/stream_header_append.sv
// stream_header_append
// Passes an imager stream through unchanged and appends a generated header
// burst (HEADER_START, HEADER_WORDS words, HEADER_END) after every FRAME_END.
// The stream cannot be stalled, so a small FIFO absorbs words arriving while a
// header is being emitted; words arriving into a full FIFO are dropped and
// flagged on the sticky overflow output.
// Optional feature macro: STREAM_HDR_TIMESTAMP_EN -- when defined, a free
// running cycle counter is latched at each FRAME_START pop and reported in
// header words 6/7; when undefined those words are zero.

`ifndef STREAM_DTYPE_DEFS
`define STREAM_DTYPE_DEFS
`define DTYPE_WIDTH        4
`define DTYPE_FRAME_START  4'h1
`define DTYPE_FRAME_END    4'h2
`define DTYPE_HEADER_START 4'h3
`define DTYPE_HEADER_END   4'h4
`define DTYPE_HEADER       4'h5
`define DTYPE_PIXEL_MASK   4'h8
`endif

module stream_header_append #(
  parameter int DATA_WIDTH   = 16,
  parameter int HEADER_WORDS = 16,
  parameter int FIFO_AW      = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  stream_header_append_if.slave        sif,
  output logic [31:0]                  frame_count,
  output logic                         overflow
);

  localparam int TW    = `DTYPE_WIDTH;
  localparam int WW    = TW + DATA_WIDTH;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int IDX_W = $clog2(HEADER_WORDS);

  localparam logic [FIFO_AW:0] PTR_ONE    = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0] FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [IDX_W-1:0] IDX_ONE    = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(HEADER_WORDS - 1);

  typedef enum logic [1:0] {
    ST_PASS,
    ST_HDR_START,
    ST_HDR_DATA,
    ST_HDR_END
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        hdr_idx_q, hdr_idx_d;
  logic                    dvo_q, dvo_d;
  logic [TW-1:0]           dtypeo_q, dtypeo_d;
  logic [DATA_WIDTH-1:0]   datao_q, datao_d;
  logic [31:0]             frame_count_q, frame_count_d;
  logic [31:0]             pix_cnt_q, pix_cnt_d;
  logic                    overflow_q;
  logic [31:0]             ts_lat;

  // ------------------------------------------------------------------
  // Input FIFO. Pointers carry one extra bit so that a full FIFO and an
  // empty FIFO (equal low bits in both cases) can be told apart.
  // ------------------------------------------------------------------
  logic [WW-1:0]           fifo_mem [DEPTH];
  logic [FIFO_AW:0]        wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]        fifo_count;
  logic                    fifo_empty, fifo_full;
  logic                    in_is_hdr, in_accept, fifo_pop, fifo_wr, in_drop;
  logic [WW-1:0]           fifo_rd_word;
  logic [TW-1:0]           pop_dtype;
  logic [DATA_WIDTH-1:0]   pop_data;

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FULL_COUNT);

  // Header-type words from upstream are discarded: this block is the only
  // legitimate header source downstream of the imager.
  assign in_is_hdr = (sif.dtypei == `DTYPE_HEADER_START) ||
                     (sif.dtypei == `DTYPE_HEADER_END)   ||
                     (sif.dtypei == `DTYPE_HEADER);
  assign in_accept = enable && sif.dvi && !in_is_hdr;

  // Pops only happen while passing the stream through.
  assign fifo_pop  = enable && (state_q == ST_PASS) && !fifo_empty;

  // A pop in the same cycle frees the slot a write into a full FIFO needs.
  assign fifo_wr   = in_accept && (!fifo_full || fifo_pop);
  assign in_drop   = in_accept && fifo_full && !fifo_pop;

  assign fifo_rd_word = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];
  assign pop_dtype    = fifo_rd_word[WW-1:DATA_WIDTH];
  assign pop_data     = fifo_rd_word[DATA_WIDTH-1:0];

  // FIFO storage write port; contents need no reset, pointers define validity.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= {sif.dtypei, sif.datai};
    end
  end

  // FIFO pointers; enable low empties the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (!enable) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Sticky drop flag; only reset or enable low clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (!enable) begin
      overflow_q <= 1'b0;
    end else if (in_drop) begin
      overflow_q <= 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Timestamp: free-running cycle counter sampled at FRAME_START pops.
  // ------------------------------------------------------------------
`ifdef STREAM_HDR_TIMESTAMP_EN
  logic [31:0] ts_cnt_q;
  logic [31:0] ts_lat_q;

  // Free-running counter, cleared by reset only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
    end
  end

  // Capture the counter when a FRAME_START leaves the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_lat_q <= '0;
    end else if (!enable) begin
      ts_lat_q <= '0;
    end else if (fifo_pop && (pop_dtype == `DTYPE_FRAME_START)) begin
      ts_lat_q <= ts_cnt_q;
    end
  end

  assign ts_lat = ts_lat_q;
`else
  assign ts_lat = '0;
`endif

  // ------------------------------------------------------------------
  // Header payload table, one entry per header word index.
  // Words 2/3 are frame-length slots the DRAM writer fills in later.
  // ------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] hdr_word [HEADER_WORDS];

  for (genvar gi = 0; gi < HEADER_WORDS; gi++) begin : g_hdr_word
    if (gi == 0) begin : g_fc_lo
      assign hdr_word[gi] = DATA_WIDTH'(frame_count_q[15:0]);
    end else if (gi == 1) begin : g_fc_hi
      assign hdr_word[gi] = DATA_WIDTH'(frame_count_q[31:16]);
    end else if (gi == 4) begin : g_pix_lo
      assign hdr_word[gi] = DATA_WIDTH'(pix_cnt_q[15:0]);
    end else if (gi == 5) begin : g_pix_hi
      assign hdr_word[gi] = DATA_WIDTH'(pix_cnt_q[31:16]);
    end else if (gi == 6) begin : g_ts_lo
      assign hdr_word[gi] = DATA_WIDTH'(ts_lat[15:0]);
    end else if (gi == 7) begin : g_ts_hi
      assign hdr_word[gi] = DATA_WIDTH'(ts_lat[31:16]);
    end else begin : g_zero
      assign hdr_word[gi] = '0;
    end
  end

  // ------------------------------------------------------------------
  // Formatter FSM
  // ------------------------------------------------------------------

  // Next state, next output word and counter updates.
  always_comb begin
    state_d       = state_q;
    hdr_idx_d     = hdr_idx_q;
    dvo_d         = 1'b0;
    dtypeo_d      = dtypeo_q;
    datao_d       = datao_q;
    frame_count_d = frame_count_q;
    pix_cnt_d     = pix_cnt_q;

    if (!enable) begin
      // Flush: abandon any header in progress without its HEADER_END.
      state_d       = ST_PASS;
      hdr_idx_d     = '0;
      frame_count_d = '0;
      pix_cnt_d     = '0;
    end else begin
      case (state_q)
        ST_PASS: begin
          if (fifo_pop) begin
            dvo_d    = 1'b1;
            dtypeo_d = pop_dtype;
            datao_d  = pop_data;
            if (pop_dtype == `DTYPE_FRAME_START) begin
              pix_cnt_d = '0;
            end else if ((pop_dtype & `DTYPE_PIXEL_MASK) != '0) begin
              pix_cnt_d = pix_cnt_q + 32'd1;
            end
            if (pop_dtype == `DTYPE_FRAME_END) begin
              state_d = ST_HDR_START;
            end
          end
        end
        ST_HDR_START: begin
          dvo_d     = 1'b1;
          dtypeo_d  = `DTYPE_HEADER_START;
          datao_d   = '0;
          hdr_idx_d = '0;
          state_d   = ST_HDR_DATA;
        end
        ST_HDR_DATA: begin
          dvo_d    = 1'b1;
          dtypeo_d = `DTYPE_HEADER;
          datao_d  = hdr_word[hdr_idx_q];
          if (hdr_idx_q == LAST_IDX) begin
            state_d = ST_HDR_END;
          end else begin
            hdr_idx_d = hdr_idx_q + IDX_ONE;
          end
        end
        ST_HDR_END: begin
          dvo_d         = 1'b1;
          dtypeo_d      = `DTYPE_HEADER_END;
          datao_d       = '0;
          frame_count_d = frame_count_q + 32'd1;
          state_d       = ST_PASS;
        end
        default: begin
          state_d = ST_PASS;
        end
      endcase
    end
  end

  // State, counters and registered output word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_PASS;
      hdr_idx_q     <= '0;
      dvo_q         <= 1'b0;
      dtypeo_q      <= '0;
      datao_q       <= '0;
      frame_count_q <= '0;
      pix_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      hdr_idx_q     <= hdr_idx_d;
      dvo_q         <= dvo_d;
      dtypeo_q      <= dtypeo_d;
      datao_q       <= datao_d;
      frame_count_q <= frame_count_d;
      pix_cnt_q     <= pix_cnt_d;
    end
  end

  assign sif.dvo     = dvo_q;
  assign sif.dtypeo  = dtypeo_q;
  assign sif.datao   = datao_q;
  assign frame_count = frame_count_q;
  assign overflow    = overflow_q;

endmodule
